// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, baud presets for a 25 MHz clock, byte width.
// Used by the transmitter and intended for reuse by the receiver.
package uart_pkg;

   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned BAUD_115200 = 217;
   localparam int unsigned BAUD_9600   = 2604;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Even parity over one data byte.
   function automatic logic even_parity(input logic [BYTE_W-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_transmit_if.sv
// Valid/ready byte handshake into the UART transmitter.
// The producer uses the master modport; the transmitter uses the slave modport.
interface uart_transmit_if;
   import uart_pkg::*;

   logic [BYTE_W-1:0] tx_byte;
   logic              tx_valid;
   logic              tx_ready;

   modport master (output tx_byte, output tx_valid, input tx_ready);
   modport slave  (input tx_byte, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CYCLES_PER_BIT-1 while enabled and raises a registered
// bit_end_o strobe during the last cycle of each bit period.
module uart_bit_timer #(
   parameter int unsigned CYCLES_PER_BIT = 217
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable_i,
   input  logic clear_i,
   output logic bit_end_o
);

   localparam int unsigned CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bit_end_q, bit_end_d;

   // Strobe is computed from the next count so it lines up with the final cycle.
   always_comb begin
      cnt_d     = cnt_q;
      bit_end_d = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      bit_end_d = enable_i && !clear_i && (cnt_d == LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         bit_end_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_end_q <= bit_end_d;
      end
   end

   assign bit_end_o = bit_end_q;

endmodule

// File: rtl/uart_transmit.sv
// UART transmitter: 8N1 frames, LSB first, valid/ready byte input, registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmit
   import uart_pkg::*;
#(
   parameter int unsigned CYCLES_PER_BIT = BAUD_115200
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   uart_transmit_if.slave  tx_if,
   output logic            o_serial_tx,
   output logic            o_tx_active,
   output logic            o_tx_done
);

   uart_state_e       state_q, state_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic              serial_q, serial_d;
   logic              ready_q;
   logic              active_q;
   logic              done_q, done_d;
   logic              accept_c;
   logic              bit_end;
`ifdef UART_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   assign accept_c = tx_if.tx_valid && ready_q;

   uart_bit_timer #(
      .CYCLES_PER_BIT (CYCLES_PER_BIT)
   ) u_bit_timer (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .enable_i  (state_q != IDLE),
      .clear_i   (accept_c),
      .bit_end_o (bit_end)
   );

   // Next-state logic; the line level is derived from the next state so it is registered.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      done_d    = 1'b0;
      serial_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept_c) begin
               shift_d   = tx_if.tx_byte;
               bit_idx_d = 3'd0;
               state_d   = START;
`ifdef UART_TX_PARITY_EN
               parity_d  = even_parity(tx_if.tx_byte);
`endif
            end
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[BYTE_W-1:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
`endif
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   serial_d = 1'b0;
         DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  serial_d = parity_q;
`endif
         default: serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= 3'd0;
         serial_q  <= 1'b1;
         ready_q   <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         serial_q  <= serial_d;
         ready_q   <= (state_d == IDLE);
         active_q  <= (state_d != IDLE);
         done_q    <= done_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) parity_q <= 1'b0;
      else          parity_q <= parity_d;
   end
`endif

   assign tx_if.tx_ready = ready_q;
   assign o_serial_tx    = serial_q;
   assign o_tx_active    = active_q;
   assign o_tx_done      = done_q;

endmodule
